// File: rtl/mem_read_streamer.sv
// ============================================================================
// Module      : mem_read_streamer
// Description : Sweeps a contiguous, wrapping address range on one read port
//               of a synchronous memory and streams each word out on a
//               valid/ready interface. A 2-entry skid buffer absorbs the
//               memory's one-cycle read latency so backpressure never drops
//               or duplicates a word.
//               Optional feature macro: MEM_RD_CHECKSUM_EN (adds a running
//               XOR checksum of accepted words on the checksum port).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_read_streamer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DEPTH-1:0] base_addr,
  input  logic [DEPTH:0]   len,
  output logic             busy,
  output logic             done,
  output logic             mem_we,
  output logic [DEPTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_rdData,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef MEM_RD_CHECKSUM_EN
  output logic [DEPTH-1:0] out_addr,
  output logic [WIDTH-1:0] checksum
`else
  output logic [DEPTH-1:0] out_addr
`endif
);

  localparam logic [DEPTH:0] LEN_ONE = {{DEPTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [DEPTH:0]   remaining;

  // Skid buffer: two {addr, data} entries, head at rd_ptr
  logic [WIDTH-1:0] buf_data [2];
  logic [DEPTH-1:0] buf_addr [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  // One read may be in flight; its address travels alongside it
  logic             inflight;
  logic [DEPTH-1:0] inflight_addr;

  logic             pop;
  logic [2:0]       total;
  logic [2:0]       left;
  logic             issue;

  assign mem_we    = 1'b0;
  assign out_valid = (count != 2'd0);
  assign out_data  = buf_data[rd_ptr];
  assign out_addr  = buf_addr[rd_ptr];

  // Handshake and issue decision: a new read is allowed only if the words
  // still owned after this edge (buffered + in flight - accepted) leave room.
  always_comb begin
    pop   = out_valid & out_ready;
    total = {1'b0, count} + {2'b00, inflight};
    left  = total - {2'b00, pop};
    issue = (state == S_RUN) && (left < 3'd2);
  end

  // Sweep control FSM with registered busy/done/mem_addr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              state     <= S_RUN;
              busy      <= 1'b1;
              mem_addr  <= base_addr;
              remaining <= len;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            mem_addr  <= mem_addr + 1'b1;
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (left == 3'd0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Track the in-flight read, capture returning data, advance buffer pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight      <= 1'b0;
      inflight_addr <= '0;
      buf_data[0]   <= '0;
      buf_data[1]   <= '0;
      buf_addr[0]   <= '0;
      buf_addr[1]   <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      count         <= 2'd0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_addr <= mem_addr;
      end
      if (inflight) begin
        buf_data[wr_ptr] <= mem_rdData;
        buf_addr[wr_ptr] <= inflight_addr;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= left[1:0];
    end
  end

`ifdef MEM_RD_CHECKSUM_EN
  // Running XOR of accepted words, cleared when a sweep is started
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum <= '0;
    end else if ((state == S_IDLE) && start) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum ^ out_data;
    end
  end
`endif

endmodule

`default_nettype wire
